// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle subtractor, CHUNK bits per clock, LSB chunk first
// Result and final borrow are published only at the last step; start is honoured in IDLE only.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [CHUNK:0]   step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            shadow_q <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            shadow_q <= shadow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands shift right so the active chunk always sits in the low CHUNK bits;
    // the top bit of the (CHUNK+1)-bit difference is the chunk's borrow-out.
    always_comb begin
        step     = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, br_q};
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        shadow_d = shadow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    br_d     = bin;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            BUSY: begin
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                br_d     = step[CHUNK];
                shadow_d = (shadow_q >> CHUNK) | (WIDTH'(step[CHUNK-1:0]) << (WIDTH - CHUNK));
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d = shadow_d;
                    bout_d = step[CHUNK];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized bench for serial_subtractor in four WIDTH/CHUNK configurations
module tb_serial_subtractor;
    localparam int NCFG = 4;
    localparam int CFG_W [NCFG] = '{8, 8, 16, 12};
    localparam int CFG_C [NCFG] = '{1, 4, 4, 12};
    localparam int NDIR = 6;
    localparam longint DIR_A [NDIR] = '{5, 3, 0, -1, -1, 'h80};
    localparam longint DIR_B [NDIR] = '{3, 5, 0, -1, 0, 1};
    localparam bit     DIR_I [NDIR] = '{0, 0, 1, 0, 0, 0};

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_blk_done = 0;

    always #5 clk = ~clk;

    // Returns {borrow, 16-bit difference} from plain integer arithmetic.
    function automatic logic [16:0] ref_sub(input int w, input longint x, input longint y, input logic bi);
        longint mask, d;
        logic   bo;
        mask = (longint'(1) << w) - 1;
        d    = (x - y - longint'(bi)) & mask;
        bo   = (x < y + longint'(bi));
        return {bo, d[15:0]};
    endfunction

    task automatic pin(input string name, input logic [16:0] got, input logic [16:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        pin("ref_5_3",      ref_sub(8, 'h05, 'h03, 1'b0),   17'h00002);
        pin("ref_3_5",      ref_sub(8, 'h03, 'h05, 1'b0),   17'h100FE);
        pin("ref_0_0_bin",  ref_sub(8, 'h00, 'h00, 1'b1),   17'h100FF);
        pin("ref_ff_ff",    ref_sub(8, 'hFF, 'hFF, 1'b0),   17'h00000);
        pin("ref_80_01",    ref_sub(8, 'h80, 'h01, 1'b0),   17'h0007F);
        pin("ref_w16_0_1",  ref_sub(16, 'h0, 'h1, 1'b0),    17'h1FFFF);
        pin("ref_w12_fff",  ref_sub(12, 'hFFF, 'h0, 1'b0),  17'h00FFF);
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = CFG_W[g];
        localparam int C = CFG_C[g];
        localparam int N = W / C;

        logic         rst, start, bin, busy, done, bout;
        logic [W-1:0] a, b, diff;

        logic [W-1:0] m_diff = '0;
        logic         m_bout = 1'b0;
        logic [W-1:0] p_diff = '0;
        logic         p_bout = 1'b0;
        int           left = 0;
        int           ops = 0;
        bit           chk = 1'b0;

        serial_subtractor #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .a    (a),
            .b    (b),
            .bin  (bin),
            .busy (busy),
            .done (done),
            .diff (diff),
            .bout (bout)
        );

        // Model: an accepted op occupies N+1 further edges; the result appears with the done cycle.
        always @(posedge clk) begin
            logic [16:0] r;
            if (rst) begin
                left   = 0;
                m_diff = '0;
                m_bout = 1'b0;
            end else if (left == 0) begin
                if (start) begin
                    r      = ref_sub(W, longint'(a), longint'(b), bin);
                    p_diff = r[W-1:0];
                    p_bout = r[16];
                    left   = N + 1;
                    ops++;
                end
            end else begin
                left--;
                if (left == 1) begin
                    m_diff = p_diff;
                    m_bout = p_bout;
                end
            end
        end

        always @(negedge clk) begin
            if (chk) begin
                n_cmp++;
                if (busy !== (left != 0) || done !== (left == 1) || diff !== m_diff || bout !== m_bout) begin
                    n_fail++;
                    $display("FAIL cycle_cfg%0d t=%0t busy/done/diff/bout got %b %b %h %b want %b %b %h %b",
                             g, $time, busy, done, diff, bout, (left != 0), (left == 1), m_diff, m_bout);
                end
            end
        end

        task automatic wait_idle();
            int k;
            k = 0;
            while (busy && k < 64) begin
                @(negedge clk);
                k++;
            end
        endtask

        task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
            int n;
            bit got;
            wait_idle();
            a = ta;
            b = tb;
            bin = tbin;
            start = 1'b1;
            n = 0;
            got = 1'b0;
            while (!got && n < 64) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                start = (n == 1);
                a = W'($urandom);
                b = W'($urandom);
                bin = 1'($urandom);
                if (done) got = 1'b1;
            end
            start = 1'b0;
            n_cmp++;
            if (n != N + 1) begin
                n_fail++;
                $display("FAIL latency_cfg%0d: got %0d edges want %0d", g, n, N + 1);
            end
        endtask

        initial begin
            int cyc;
            rst = 1'b1;
            start = 1'b0;
            a = '0;
            b = '0;
            bin = 1'b0;
            repeat (2) @(negedge clk);
            chk = 1'b1;
            n_cmp++;
            if ({busy, done, bout} !== 3'b000 || diff !== '0) begin
                n_fail++;
                $display("FAIL reset_cfg%0d: got busy=%b done=%b diff=%h bout=%b want all zero",
                         g, busy, done, diff, bout);
            end
            rst = 1'b0;

            for (int i = 0; i < NDIR; i++) op(W'(DIR_A[i]), W'(DIR_B[i]), DIR_I[i]);

            start = 1'b1;
            repeat (4 * (N + 2)) begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
                bin = 1'($urandom);
            end
            start = 1'b0;

            wait_idle();
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            op(W'($urandom), W'($urandom), 1'($urandom));

            cyc = 0;
            while (ops < 280 && cyc < 15000) begin
                @(negedge clk);
                cyc++;
                a = W'($urandom);
                b = W'($urandom);
                bin = 1'($urandom);
                start = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 299) == 0);
            end
            rst = 1'b0;
            start = 1'b0;
            repeat (N + 3) @(negedge clk);
            n_blk_done++;
        end
    end

    initial begin
        int t;
        t = 0;
        while (n_blk_done < NCFG && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (n_blk_done < NCFG) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got %0d configs finished want %0d", n_blk_done, NCFG);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
